// File: rtl/layer_output_backprop_pkg.sv
// Shared fixed-point definitions for the layer modules: word format, saturation
// limits, the 1.0 constant, a saturating narrow helper and the backprop FSM states.
package layer_output_backprop_pkg;

  localparam int N = 16;
  localparam int F = 8;

  localparam logic [N-1:0] ONE     = N'(1 << F);
  localparam logic [N-1:0] SAT_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0] SAT_MIN = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_READ,
    S_UPDATE,
    S_DONE
  } state_e;

  // Clamp a wide signed intermediate back into the N-bit word range.
  function automatic logic [N-1:0] sat_n(input logic signed [2*N:0] x);
    logic signed [2*N:0] hi, lo;
    hi = {{(N+2){1'b0}}, {(N-1){1'b1}}};
    lo = {{(N+2){1'b1}}, {(N-1){1'b0}}};
    if (x > hi)      return SAT_MAX;
    else if (x < lo) return SAT_MIN;
    else             return x[N-1:0];
  endfunction

endpackage

// File: rtl/layer_output_backprop_if.sv
// Control, activation and weight-store bus of the output-layer update block.
interface layer_output_backprop_if #(
  parameter int sl    = 2,
  parameter int slhid = 3,
  parameter int AW    = 3
);
  import layer_output_backprop_pkg::*;

  logic                    start;
  logic [sl-1:0][N-1:0]    ly;
  logic [sl-1:0][N-1:0]    lt;
  logic [slhid-1:0][N-1:0] lyhid;
  logic [AW-1:0]           w_addr;
  logic [N-1:0]            w_rd_data;
  logic                    w_wr_en;
  logic [N-1:0]            w_wr_data;
  logic [sl-1:0][N-1:0]    delta;
  logic                    busy;
  logic                    done;

  modport master (
    output start, ly, lt, lyhid, w_rd_data,
    input  w_addr, w_wr_en, w_wr_data, delta, busy, done
  );

  modport slave (
    input  start, ly, lt, lyhid, w_rd_data,
    output w_addr, w_wr_en, w_wr_data, delta, busy, done
  );

endinterface

// File: rtl/layer_output_backprop_fx_mul_sat.sv
// Signed fixed-point multiply: full product shifted right by F (floor), then
// saturated to OW bits. OW = 2*N keeps the whole shifted product.
module fx_mul_sat #(
  parameter int N  = 16,
  parameter int F  = 8,
  parameter int OW = 16
) (
  input  logic signed [N-1:0]  a,
  input  logic signed [N-1:0]  b,
  output logic signed [OW-1:0] y
);

  logic signed [2*N-1:0] prod, shifted;

  assign prod    = $signed({{N{a[N-1]}}, a}) * $signed({{N{b[N-1]}}, b});
  assign shifted = prod >>> F;

  if (OW == 2*N) begin : g_full
    assign y = shifted;
  end else begin : g_sat
    logic ovf;
    assign ovf = shifted[2*N-1:OW-1] != {(2*N-OW+1){shifted[2*N-1]}};
    assign y   = ovf ? {shifted[2*N-1], {(OW-1){~shifted[2*N-1]}}} : shifted[OW-1:0];
  end

endmodule

// File: rtl/layer_output_backprop.sv
// Output-layer weight update: latch one sample's error, then walk the weight
// store (weights then bias per output node) applying w -= (delta*h) >> LR_SHIFT.
module layer_output_backprop
  import layer_output_backprop_pkg::*;
#(
  parameter int sl       = 2,
  parameter int slhid    = 3,
  parameter int LR_SHIFT = 4,
  parameter int AW       = $clog2(sl*(slhid+1))
) (
  input logic                    clk,
  input logic                    rst_n,
  layer_output_backprop_if.slave bus
);

  localparam int JW = (sl > 1) ? $clog2(sl) : 1;
  localparam int IW = ($clog2(slhid+1) > 0) ? $clog2(slhid+1) : 1;

  state_e                  state_q, state_d;
  logic [JW-1:0]           j_q, j_d;
  logic [IW-1:0]           i_q, i_d;
  logic [AW-1:0]           addr_q, addr_d;
  logic [sl-1:0][N-1:0]    delta_q, delta_d, delta_in;
  logic [slhid-1:0][N-1:0] h_q, h_d;

  // Per-node error, saturated from the (N+1)-bit difference.
  for (genvar g = 0; g < sl; g++) begin : g_lane
    logic [N:0] diff;
    assign diff        = {bus.ly[g][N-1], bus.ly[g]} - {bus.lt[g][N-1], bus.lt[g]};
    assign delta_in[g] = sat_n({{N{diff[N]}}, diff});
  end

  // Bias slot sits at index slhid with a constant input of 1.0.
  logic [slhid:0][N-1:0]  h_ext;
  logic signed [2*N-1:0]  grad, step;
  logic signed [2*N:0]    w_ext, w_diff;
  logic [N-1:0]           w_new;

  assign h_ext = {ONE, h_q};

  fx_mul_sat #(.N(N), .F(F), .OW(2*N)) u_mul (
    .a (delta_q[j_q]),
    .b (h_ext[i_q]),
    .y (grad)
  );

  assign step   = grad >>> LR_SHIFT;
  assign w_ext  = {{(N+1){bus.w_rd_data[N-1]}}, bus.w_rd_data};
  assign w_diff = w_ext - {step[2*N-1], step};
  assign w_new  = sat_n(w_diff);

  always_comb begin
    state_d = state_q;
    j_d     = j_q;
    i_d     = i_q;
    addr_d  = addr_q;
    delta_d = delta_q;
    h_d     = h_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_LATCH;
      S_LATCH: begin
        delta_d = delta_in;
        h_d     = bus.lyhid;
        j_d     = '0;
        i_d     = '0;
        addr_d  = '0;
        state_d = S_READ;
      end
      S_READ:  state_d = S_UPDATE;
      // Visit order is linear in the store, so the address is a plain counter.
      S_UPDATE: begin
        if (i_q != IW'(slhid)) begin
          i_d     = i_q + IW'(1);
          addr_d  = addr_q + AW'(1);
          state_d = S_READ;
        end else if (j_q != JW'(sl-1)) begin
          i_d     = '0;
          j_d     = j_q + JW'(1);
          addr_d  = addr_q + AW'(1);
          state_d = S_READ;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      j_q     <= '0;
      i_q     <= '0;
      addr_q  <= '0;
      delta_q <= '0;
      h_q     <= '0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      i_q     <= i_d;
      addr_q  <= addr_d;
      delta_q <= delta_d;
      h_q     <= h_d;
    end
  end

  // Strobes decode the state register so reset clears them without a clock.
  assign bus.w_addr    = addr_q;
  assign bus.w_wr_en   = (state_q == S_UPDATE);
  assign bus.w_wr_data = (state_q == S_UPDATE) ? w_new : '0;
  assign bus.delta     = delta_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);

endmodule

// File: tb/tb_layer_output_backprop.sv
// Bench for layer_output_backprop: two instances (LR_SHIFT 0 and 4) each with a
// behavioural weight store; results checked against an arithmetic model.
module tb_layer_output_backprop;

  localparam int SL = 2, SLH = 3, AWD = 3, NW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  layer_output_backprop_if #(.sl(SL), .slhid(SLH), .AW(AWD)) b0 ();
  layer_output_backprop_if #(.sl(SL), .slhid(SLH), .AW(AWD)) b4 ();

  layer_output_backprop #(.sl(SL), .slhid(SLH), .LR_SHIFT(0), .AW(AWD)) u_lr0 (
    .clk(clk), .rst_n(rst_n), .bus(b0));
  layer_output_backprop #(.sl(SL), .slhid(SLH), .LR_SHIFT(4), .AW(AWD)) u_lr4 (
    .clk(clk), .rst_n(rst_n), .bus(b4));

  logic [15:0] mem0 [NW], mem4 [NW], pre0 [NW], pre4 [NW];
  logic        load0, load4;
  int          wa0[$], wd0[$], wa4[$], wd4[$];

  always @(posedge clk) begin
    if (load0) begin
      for (int k = 0; k < NW; k++) mem0[k] <= pre0[k];
    end else if (b0.w_wr_en) begin
      mem0[b0.w_addr] <= b0.w_wr_data;
      wa0.push_back(int'(b0.w_addr));
      wd0.push_back(int'($signed(b0.w_wr_data)));
    end
    b0.w_rd_data <= mem0[b0.w_addr];
  end

  always @(posedge clk) begin
    if (load4) begin
      for (int k = 0; k < NW; k++) mem4[k] <= pre4[k];
    end else if (b4.w_wr_en) begin
      mem4[b4.w_addr] <= b4.w_wr_data;
      wa4.push_back(int'(b4.w_addr));
      wd4.push_back(int'($signed(b4.w_wr_data)));
    end
    b4.w_rd_data <= mem4[b4.w_addr];
  end

  int checks = 0, fails = 0;
  int sy[2], st[2], sh[3], sw[8], ew[8], edl[2];

  typedef struct {
    logic             busy, done, wr_en;
    logic [2:0]       addr;
    logic [15:0]      wdata;
    logic [1:0][15:0] delta;
  } obs_t;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic obs_t snap(input int inst);
    obs_t o;
    if (inst == 0) begin
      o.busy = b0.busy; o.done = b0.done; o.wr_en = b0.w_wr_en;
      o.addr = b0.w_addr; o.wdata = b0.w_wr_data; o.delta = b0.delta;
    end else begin
      o.busy = b4.busy; o.done = b4.done; o.wr_en = b4.w_wr_en;
      o.addr = b4.w_addr; o.wdata = b4.w_wr_data; o.delta = b4.delta;
    end
    return o;
  endfunction

  function automatic int rnd16();
    logic [15:0] r;
    r = 16'($urandom);
    return int'($signed(r));
  endfunction

  function automatic longint satw(input longint x);
    if (x > 32767)  return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  // w - floor(floor(d*h / 2^8) / 2^lr), clamped to the 16-bit range.
  function automatic int model_w(input int w, input int d, input int h, input int lr);
    longint p, g, s;
    p = longint'(d) * longint'(h);
    g = p >>> 8;
    s = g >>> lr;
    return int'(satw(longint'(w) - s));
  endfunction

  task automatic set_start(input int inst, input logic v);
    if (inst == 0) b0.start = v; else b4.start = v;
  endtask

  task automatic drive_in(input int inst, input bit scramble);
    logic [15:0] yv, tv, hv;
    for (int j = 0; j < SL; j++) begin
      yv = scramble ? 16'($urandom) : 16'(sy[j]);
      tv = scramble ? 16'($urandom) : 16'(st[j]);
      if (inst == 0) begin b0.ly[j] = yv; b0.lt[j] = tv; end
      else           begin b4.ly[j] = yv; b4.lt[j] = tv; end
    end
    for (int i = 0; i < SLH; i++) begin
      hv = scramble ? 16'($urandom) : 16'(sh[i]);
      if (inst == 0) b0.lyhid[i] = hv; else b4.lyhid[i] = hv;
    end
  endtask

  task automatic prepare(input int inst);
    int lr;
    lr = (inst == 0) ? 0 : 4;
    @(negedge clk);
    drive_in(inst, 1'b0);
    for (int k = 0; k < NW; k++) begin
      if (inst == 0) pre0[k] = 16'(sw[k]); else pre4[k] = 16'(sw[k]);
    end
    if (inst == 0) load0 = 1'b1; else load4 = 1'b1;
    @(negedge clk);
    load0 = 1'b0; load4 = 1'b0;
    wa0.delete(); wd0.delete(); wa4.delete(); wd4.delete();
    for (int j = 0; j < SL; j++) begin
      edl[j] = int'(satw(longint'(sy[j]) - longint'(st[j])));
      for (int i = 0; i <= SLH; i++)
        ew[j*(SLH+1)+i] = model_w(sw[j*(SLH+1)+i], edl[j], (i == SLH) ? 256 : sh[i], lr);
    end
  endtask

  // One full pass; optional stray start pulse mid-pass; inputs scrambled after LATCH.
  task automatic run(input int inst, input string tag, input int pulse_at);
    obs_t o;
    int   cyc, n, a, d;
    prepare(inst);
    set_start(inst, 1'b1);
    @(negedge clk);
    set_start(inst, 1'b0);
    cyc = 1;
    o = snap(inst);
    while (!o.done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      set_start(inst, cyc == pulse_at);
      if (cyc == 3) drive_in(inst, 1'b1);
      o = snap(inst);
    end
    set_start(inst, 1'b0);
    chk({tag, "_done_latency"}, cyc, 18);
    for (int j = 0; j < SL; j++)
      chk($sformatf("%s_delta%0d", tag, j), $signed(o.delta[j]), edl[j]);
    @(negedge clk);
    o = snap(inst);
    chk({tag, "_busy_after"}, o.busy, 0);
    chk({tag, "_done_pulse"}, o.done, 0);
    repeat (3) @(negedge clk);
    o = snap(inst);
    chk({tag, "_idle"}, o.busy, 0);
    n = (inst == 0) ? wa0.size() : wa4.size();
    chk({tag, "_write_count"}, n, NW);
    for (int k = 0; k < NW && k < n; k++) begin
      a = (inst == 0) ? wa0[k] : wa4[k];
      d = (inst == 0) ? wd0[k] : wd4[k];
      chk($sformatf("%s_w%0d_addr", tag, k), a, k);
      chk($sformatf("%s_w%0d_data", tag, k), d, ew[k]);
    end
  endtask

  obs_t oo;
  int   cyc, n;

  initial begin
    rst_n = 1'b1;
    load0 = 1'b0; load4 = 1'b0;
    b0.start = 1'b0; b4.start = 1'b0;
    b0.ly = '0; b0.lt = '0; b0.lyhid = '0;
    b4.ly = '0; b4.lt = '0; b4.lyhid = '0;

    // Reset asserted mid-cycle must clear outputs without a clock edge.
    #3 rst_n = 1'b0;
    #1;
    oo = snap(0);
    chk("rst_busy", oo.busy, 0);
    chk("rst_done", oo.done, 0);
    chk("rst_wr_en", oo.wr_en, 0);
    chk("rst_addr", oo.addr, 0);
    chk("rst_wdata", oo.wdata, 0);
    chk("rst_delta", oo.delta, 0);
    oo = snap(1);
    chk("rst_busy_lr4", oo.busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    oo = snap(0);
    chk("rel_busy", oo.busy, 0);

    // Basic pass, zero weights.
    sy = '{256, 0}; st = '{128, 0}; sh = '{256, 128, -256}; sw = '{default: 0};
    run(0, "basic", -1);
    chk("basic_mem0", $signed(mem0[0]), -128);
    chk("basic_mem1", $signed(mem0[1]), -64);
    chk("basic_mem2", $signed(mem0[2]), 128);
    chk("basic_mem3", $signed(mem0[3]), -128);
    chk("basic_mem5", $signed(mem0[5]), 0);
    chk("basic_delta_const", edl[0], 128);

    // Delta and weight saturation.
    sy = '{-32768, 0}; st = '{32767, 0}; sh = '{256, 0, 0};
    sw = '{32000, 0, 0, 0, 0, 0, 0, 0};
    run(0, "sat", -1);
    chk("sat_mem0", $signed(mem0[0]), 32767);

    // Learning-rate shift, including floor of a negative step.
    sy = '{256, 0}; st = '{0, 1}; sh = '{256, 0, 0}; sw = '{default: 100};
    run(1, "lr4", -1);
    chk("lr4_mem0", $signed(mem4[0]), 84);
    chk("lr4_mem4", $signed(mem4[4]), 101);

    // Stray start while busy is ignored.
    for (int k = 0; k < 2; k++) begin sy[k] = rnd16(); st[k] = rnd16(); end
    for (int k = 0; k < 3; k++) sh[k] = rnd16();
    for (int k = 0; k < 8; k++) sw[k] = rnd16();
    run(0, "midstart", 6);

    // Start held high: back-to-back passes.
    prepare(0);
    set_start(0, 1'b1);
    @(negedge clk);
    cyc = 1;
    oo = snap(0);
    while (!oo.done && cyc < 200) begin @(negedge clk); cyc++; oo = snap(0); end
    chk("hold_done1", cyc, 18);
    @(negedge clk);
    oo = snap(0);
    chk("hold_idle_gap", oo.busy, 0);
    @(negedge clk);
    oo = snap(0);
    chk("hold_restart", oo.busy, 1);
    set_start(0, 1'b0);
    cyc = 2;
    while (!oo.done && cyc < 200) begin @(negedge clk); cyc++; oo = snap(0); end
    chk("hold_done2", cyc, 19);
    repeat (3) @(negedge clk);
    chk("hold_writes", wa0.size(), 16);

    // Reset in the middle of the fourth write.
    for (int k = 0; k < 8; k++) sw[k] = rnd16();
    prepare(0);
    set_start(0, 1'b1);
    @(negedge clk);
    set_start(0, 1'b0);
    n = 0;
    while (!(b0.w_wr_en === 1'b1 && wa0.size() == 3) && n < 100) begin @(negedge clk); n++; end
    chk("mrst_reached", n < 100, 1);
    rst_n = 1'b0;
    #1;
    oo = snap(0);
    chk("mrst_wr_en", oo.wr_en, 0);
    chk("mrst_busy", oo.busy, 0);
    chk("mrst_wdata", oo.wdata, 0);
    @(negedge clk);
    @(negedge clk);
    chk("mrst_writes", wa0.size(), 3);
    for (int k = 0; k < NW; k++)
      chk($sformatf("mrst_mem%0d", k), $signed(mem0[k]), (k < 3) ? ew[k] : sw[k]);
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 8; k++) sw[k] = rnd16();
    run(0, "after_rst", -1);

    // Randomised passes on both learning rates.
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 2; k++) begin sy[k] = rnd16(); st[k] = rnd16(); end
      for (int k = 0; k < 3; k++) sh[k] = rnd16();
      for (int k = 0; k < 8; k++) sw[k] = rnd16();
      run(r % 2, $sformatf("rnd%0d", r), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
